// File: rtl/mldsa_ctrl_pkg.sv
// Shared types and defaults for the MLDSA engine control blocks.
// Includes the arbiter state/owner encodings and the round-robin pick rule.
package mldsa_ctrl_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_START = 3'd1,
    ARB_RUN   = 3'd2,
    ARB_DONE  = 3'd3,
    ARB_ERR   = 3'd4
  } mldsa_arb_state_e;

  typedef enum logic {
    PRIM = 1'b0,
    SEC  = 1'b1
  } mldsa_arb_owner_e;

  localparam int MLDSA_ARB_TIMEOUT_DEFAULT = 8191;

  // A lone requester always wins; on a tie the one that did not go last wins.
  function automatic mldsa_arb_owner_e arb_pick(input logic prim_req, input logic sec_req,
                                                input mldsa_arb_owner_e last_owner);
    if (prim_req && sec_req) return (last_owner == PRIM) ? SEC : PRIM;
    return prim_req ? PRIM : SEC;
  endfunction

endpackage

// File: rtl/mldsa_seq_res_arb_if.sv
// Requester, engine and zeroize signals between two sequencers, the arbiter and the engine.
// The arbiter uses the slave view; sequencers/engine (or a bench) drive the master view.
interface mldsa_seq_res_arb_if #(
  parameter int OP_W = 8
);
  logic            zeroize_i;
  logic            prim_req_i;
  logic [OP_W-1:0] prim_op_i;
  logic            sec_req_i;
  logic [OP_W-1:0] sec_op_i;
  logic            eng_done_i;
  logic            prim_gnt_o;
  logic            sec_gnt_o;
  logic            prim_done_o;
  logic            sec_done_o;
  logic            eng_start_o;
  logic [OP_W-1:0] eng_op_o;
  logic            eng_abort_o;
  logic            busy_o;
  logic            err_o;

  modport slave (
    input  zeroize_i, prim_req_i, prim_op_i, sec_req_i, sec_op_i, eng_done_i,
    output prim_gnt_o, sec_gnt_o, prim_done_o, sec_done_o,
           eng_start_o, eng_op_o, eng_abort_o, busy_o, err_o
  );

  modport master (
    output zeroize_i, prim_req_i, prim_op_i, sec_req_i, sec_op_i, eng_done_i,
    input  prim_gnt_o, sec_gnt_o, prim_done_o, sec_done_o,
           eng_start_o, eng_op_o, eng_abort_o, busy_o, err_o
  );

endinterface

// File: rtl/mldsa_arb_wdog.sv
// Saturating watchdog counter for the engine RUN phase.
// expired is high on the cycle whose closing edge would bring the count to TIMEOUT.
module mldsa_arb_wdog #(
  parameter int TIMEOUT = 8191
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of the order in which the always_ff blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && ((cnt_q == CNT_LAST) || (cnt_q == CNT_MAX));

endmodule

// File: rtl/mldsa_seq_res_arb.sv
// Two-requester round-robin arbiter and launch controller for one shared MLDSA engine.
// Grants, launches, waits for completion, returns a done pulse and traps hangs/protocol errors.
module mldsa_seq_res_arb
  import mldsa_ctrl_pkg::*;
#(
  parameter int OP_W    = 8,
  parameter int TIMEOUT = MLDSA_ARB_TIMEOUT_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  mldsa_seq_res_arb_if.slave bus
);
  mldsa_arb_state_e state_q;
  mldsa_arb_owner_e owner_q;
  mldsa_arb_owner_e last_owner_q;
  mldsa_arb_owner_e pick;
  logic [OP_W-1:0]  op_pick;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;
  logic             protocol_err;
  logic             wdog_err;

  assign pick    = arb_pick(bus.prim_req_i, bus.sec_req_i, last_owner_q);
  assign op_pick = (pick == PRIM) ? bus.prim_op_i : bus.sec_op_i;

  assign wd_clear  = bus.zeroize_i || (state_q == ARB_START);
  assign wd_enable = (state_q == ARB_RUN);

  // A done on the watchdog edge still wins, so the timeout only traps without done.
  assign protocol_err = bus.eng_done_i && (state_q inside {ARB_IDLE, ARB_START, ARB_DONE});
  assign wdog_err     = (state_q == ARB_RUN) && !bus.eng_done_i && wd_expired;

  mldsa_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ARB_IDLE;
      owner_q          <= SEC;
      last_owner_q     <= SEC;
      bus.prim_gnt_o   <= 1'b0;
      bus.sec_gnt_o    <= 1'b0;
      bus.prim_done_o  <= 1'b0;
      bus.sec_done_o   <= 1'b0;
      bus.eng_start_o  <= 1'b0;
      bus.eng_op_o     <= '0;
      bus.eng_abort_o  <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.err_o        <= 1'b0;
    end else begin
      bus.eng_start_o <= 1'b0;
      bus.prim_done_o <= 1'b0;
      bus.sec_done_o  <= 1'b0;
      bus.eng_abort_o <= 1'b0;

      if (bus.zeroize_i) begin
        bus.eng_abort_o <= (state_q == ARB_START) || (state_q == ARB_RUN);
        state_q         <= ARB_IDLE;
        last_owner_q    <= SEC;
        bus.prim_gnt_o  <= 1'b0;
        bus.sec_gnt_o   <= 1'b0;
        bus.eng_op_o    <= '0;
        bus.busy_o      <= 1'b0;
        bus.err_o       <= 1'b0;
      end else if (protocol_err || wdog_err) begin
        state_q        <= ARB_ERR;
        bus.prim_gnt_o <= 1'b0;
        bus.sec_gnt_o  <= 1'b0;
        bus.busy_o     <= 1'b1;
        bus.err_o      <= 1'b1;
      end else begin
        unique case (state_q)
          ARB_IDLE: begin
            if (bus.prim_req_i || bus.sec_req_i) begin
              state_q         <= ARB_START;
              owner_q         <= pick;
              bus.prim_gnt_o  <= (pick == PRIM);
              bus.sec_gnt_o   <= (pick == SEC);
              bus.eng_op_o    <= op_pick;
              bus.eng_start_o <= 1'b1;
              bus.busy_o      <= 1'b1;
            end
          end
          ARB_START: state_q <= ARB_RUN;
          ARB_RUN: begin
            if (bus.eng_done_i) begin
              state_q         <= ARB_DONE;
              bus.prim_done_o <= (owner_q == PRIM);
              bus.sec_done_o  <= (owner_q == SEC);
            end
          end
          ARB_DONE: begin
            state_q        <= ARB_IDLE;
            last_owner_q   <= owner_q;
            bus.prim_gnt_o <= 1'b0;
            bus.sec_gnt_o  <= 1'b0;
            bus.busy_o     <= 1'b0;
          end
          ARB_ERR: ;
          default: begin
            state_q        <= ARB_ERR;
            bus.prim_gnt_o <= 1'b0;
            bus.sec_gnt_o  <= 1'b0;
            bus.busy_o     <= 1'b1;
            bus.err_o      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mldsa_seq_res_arb.sv
// Self-checking bench for mldsa_seq_res_arb: directed scenarios plus randomized traffic,
// all outputs compared every cycle against an operation-level model.
module tb_mldsa_seq_res_arb;
  localparam int TB_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;

  mldsa_seq_res_arb_if #(.OP_W(8)) a ();

  mldsa_seq_res_arb #(
    .OP_W    (8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an operation is active from grant, age 0 is the launch cycle,
  // age N is the N-th cycle spent waiting on the engine.
  bit        m_active, m_in_done, m_err, m_owner, m_last, m_abort, m_pick;
  int        m_age;
  logic [7:0] m_op;

  assign m_pick = (a.prim_req_i && a.sec_req_i) ? ~m_last : ~a.prim_req_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_in_done <= 0; m_err <= 0; m_owner <= 0;
      m_last <= 1; m_abort <= 0; m_age <= 0; m_op <= '0;
    end else begin
      m_abort <= 0;
      if (a.zeroize_i) begin
        m_abort <= m_active && !m_in_done;
        m_active <= 0; m_in_done <= 0; m_err <= 0; m_op <= '0; m_last <= 1; m_age <= 0;
      end else if (m_err) begin
        m_err <= 1;
      end else if (!m_active) begin
        if (a.eng_done_i) m_err <= 1;
        else if (a.prim_req_i || a.sec_req_i) begin
          m_active <= 1; m_age <= 0; m_owner <= m_pick;
          m_op <= m_pick ? a.sec_op_i : a.prim_op_i;
        end
      end else if (m_in_done) begin
        m_active <= 0; m_in_done <= 0; m_last <= m_owner;
        if (a.eng_done_i) m_err <= 1;
      end else if (m_age == 0) begin
        if (a.eng_done_i) begin m_active <= 0; m_err <= 1; end
        else m_age <= 1;
      end else begin
        if (a.eng_done_i) m_in_done <= 1;
        else if (m_age == TB_TIMEOUT) begin m_active <= 0; m_err <= 1; end
        else m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("prim_gnt",  a.prim_gnt_o,  m_active && !m_owner);
      check("sec_gnt",   a.sec_gnt_o,   m_active && m_owner);
      check("prim_done", a.prim_done_o, m_in_done && !m_owner);
      check("sec_done",  a.sec_done_o,  m_in_done && m_owner);
      check("eng_start", a.eng_start_o, m_active && !m_in_done && (m_age == 0));
      check("eng_op",    a.eng_op_o,    m_op);
      check("eng_abort", a.eng_abort_o, m_abort);
      check("busy",      a.busy_o,      m_active || m_err);
      check("err",       a.err_o,       m_err);
    end
  end

  // Stimulus-side monitor and engine responder.
  int cyc = 0, eng_rem = 0, eng_lat = 1;
  int n_start, n_pdone, n_sdone, n_abort, start_cyc, pdone_cyc;
  bit saw_pgnt, saw_sgnt, prev_pg, prev_sg;
  int gnt_q[$], done_q[$], start_q[$];

  task automatic clear_mon();
    n_start = 0; n_pdone = 0; n_sdone = 0; n_abort = 0; start_cyc = 0; pdone_cyc = 0;
    saw_pgnt = 0; saw_sgnt = 0;
    gnt_q.delete(); done_q.delete(); start_q.delete();
  endtask

  task automatic step();
    bit fire;
    @(negedge clk);
    cyc++;
    if (a.eng_start_o) begin n_start++; start_cyc = cyc; start_q.push_back(cyc); end
    if (a.prim_done_o) begin n_pdone++; pdone_cyc = cyc; done_q.push_back(0); end
    if (a.sec_done_o) begin n_sdone++; done_q.push_back(1); end
    if (a.eng_abort_o) n_abort++;
    if (a.prim_gnt_o && !prev_pg) gnt_q.push_back(0);
    if (a.sec_gnt_o && !prev_sg) gnt_q.push_back(1);
    if (a.prim_gnt_o) saw_pgnt = 1;
    if (a.sec_gnt_o) saw_sgnt = 1;
    prev_pg = a.prim_gnt_o;
    prev_sg = a.sec_gnt_o;
    fire = 0;
    if (eng_rem > 0) begin
      if (!a.busy_o || a.err_o) eng_rem = 0;
      else begin eng_rem--; fire = (eng_rem == 0); end
    end
    if (a.eng_start_o) eng_rem = eng_lat;
    a.eng_done_i = fire;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_prim_gnt"},  a.prim_gnt_o,  0);
    check({tag, "_sec_gnt"},   a.sec_gnt_o,   0);
    check({tag, "_prim_done"}, a.prim_done_o, 0);
    check({tag, "_sec_done"},  a.sec_done_o,  0);
    check({tag, "_start"},     a.eng_start_o, 0);
    check({tag, "_op"},        a.eng_op_o,    0);
    check({tag, "_abort"},     a.eng_abort_o, 0);
    check({tag, "_busy"},      a.busy_o,      0);
    check({tag, "_err"},       a.err_o,       0);
  endtask

  initial begin
    int exp_order[4];
    int r;
    exp_order = '{0, 1, 0, 1};
    a.zeroize_i = 0; a.prim_req_i = 0; a.prim_op_i = '0;
    a.sec_req_i = 0; a.sec_op_i = '0; a.eng_done_i = 0;
    #1 rst = 1;
    #1 cmp_en = 1;
    repeat (3) step();
    rst = 0;
    check_zero("reset");

    // Single primary request, engine done 10 cycles after start.
    clear_mon(); eng_lat = 10;
    a.prim_req_i = 1; a.prim_op_i = 8'h21;
    step();
    check("single_gnt", a.prim_gnt_o, 1);
    for (int i = 0; i < 40 && n_pdone == 0; i++) step();
    a.prim_req_i = 0;
    step(); step();
    check("single_op", a.eng_op_o, 8'h21);
    check("single_starts", n_start, 1);
    check("single_pdone", n_pdone, 1);
    check("single_sdone", n_sdone, 0);
    check("single_no_sgnt", saw_sgnt, 0);
    check("single_latency", pdone_cyc - start_cyc, 11);

    // Contention: both held through four operations.
    a.zeroize_i = 1; step(); a.zeroize_i = 0;
    clear_mon(); eng_lat = 1;
    a.prim_req_i = 1; a.prim_op_i = 8'h31; a.sec_req_i = 1; a.sec_op_i = 8'h52;
    for (int i = 0; i < 60 && (n_pdone + n_sdone) < 4; i++) step();
    a.prim_req_i = 0; a.sec_req_i = 0;
    step(); step();
    check("cont_grants", gnt_q.size(), 4);
    check("cont_dones", done_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_q.size()) check("cont_gnt_order", gnt_q[i], exp_order[i]);
      if (i < done_q.size()) check("cont_done_order", done_q[i], exp_order[i]);
    end
    if (start_q.size() >= 2) check("cont_spacing", start_q[1] - start_q[0], 4);
    else check("cont_spacing_starts", start_q.size(), 2);

    // Watchdog with a hung engine.
    clear_mon(); eng_lat = 0;
    a.prim_req_i = 1; a.prim_op_i = 8'h44;
    step();
    check("wd_start", a.eng_start_o, 1);
    step();
    repeat (15) step();
    check("wd_err_before", a.err_o, 0);
    check("wd_gnt_before", a.prim_gnt_o, 1);
    step();
    check("wd_err_at", a.err_o, 1);
    check("wd_pgnt_at", a.prim_gnt_o, 0);
    check("wd_sgnt_at", a.sec_gnt_o, 0);
    a.sec_req_i = 1; a.sec_op_i = 8'h55;
    clear_mon();
    repeat (5) step();
    check("wd_ignored_p", saw_pgnt, 0);
    check("wd_ignored_s", saw_sgnt, 0);
    check("wd_err_sticky", a.err_o, 1);
    eng_lat = 3;
    a.zeroize_i = 1; step(); a.zeroize_i = 0;
    check("wd_zero_err", a.err_o, 0);
    check("wd_zero_abort", a.eng_abort_o, 0);
    step();
    check("wd_after_pgnt", a.prim_gnt_o, 1);
    check("wd_after_sgnt", a.sec_gnt_o, 0);
    check("wd_after_op", a.eng_op_o, 8'h44);
    for (int i = 0; i < 20 && n_pdone == 0; i++) step();
    a.prim_req_i = 0; a.sec_req_i = 0;
    step(); step();

    // Zeroize during RUN with a simultaneous engine done.
    eng_lat = 0;
    a.sec_req_i = 1; a.sec_op_i = 8'h66;
    step(); step(); step();
    clear_mon();
    a.zeroize_i = 1; a.eng_done_i = 1;
    step();
    a.zeroize_i = 0; a.sec_req_i = 0;
    check("zr_abort", a.eng_abort_o, 1);
    check("zr_busy", a.busy_o, 0);
    check("zr_op", a.eng_op_o, 0);
    repeat (3) step();
    check("zr_abort_count", n_abort, 1);
    check("zr_no_done", n_sdone, 0);
    check("zr_err", a.err_o, 0);

    // Spurious done in IDLE.
    a.eng_done_i = 1;
    step();
    check("sp_err", a.err_o, 1);
    check("sp_busy", a.busy_o, 1);
    a.prim_req_i = 1; a.prim_op_i = 8'h09;
    clear_mon();
    repeat (4) step();
    check("sp_no_start", n_start, 0);
    check("sp_stuck", a.err_o, 1);
    a.prim_req_i = 0;
    a.zeroize_i = 1; step(); a.zeroize_i = 0;

    // Engine done exactly on the watchdog edge.
    clear_mon(); eng_lat = TB_TIMEOUT;
    a.prim_req_i = 1; a.prim_op_i = 8'h77;
    for (int i = 0; i < 40 && n_pdone == 0; i++) step();
    a.prim_req_i = 0;
    check("bd_done", n_pdone, 1);
    check("bd_latency", pdone_cyc - start_cyc, TB_TIMEOUT + 1);
    check("bd_err", a.err_o, 0);
    step(); step();

    // Asynchronous reset mid-cycle during RUN.
    eng_lat = 0;
    a.prim_req_i = 1; a.prim_op_i = 8'h13;
    step(); step(); step();
    check("ar_busy_before", a.busy_o, 1);
    #3 rst = 1;
    #1 check_zero("async_rst");
    a.prim_req_i = 0;
    step(); step();
    rst = 0;
    step();
    check_zero("after_rst");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      r = int'($urandom_range(99));
      eng_lat = (r < 5) ? 0 : (r < 10) ? TB_TIMEOUT : int'($urandom_range(20, 1));
      if (!a.prim_req_i) begin
        if ($urandom_range(99) < 25) begin a.prim_req_i = 1; a.prim_op_i = 8'($urandom); end
      end else if (a.prim_done_o) begin
        if ($urandom_range(1) == 1) a.prim_req_i = 0;
      end else if (a.prim_gnt_o && $urandom_range(99) < 3) a.prim_req_i = 0;
      if (!a.sec_req_i) begin
        if ($urandom_range(99) < 25) begin a.sec_req_i = 1; a.sec_op_i = 8'($urandom); end
      end else if (a.sec_done_o) begin
        if ($urandom_range(1) == 1) a.sec_req_i = 0;
      end else if (a.sec_gnt_o && $urandom_range(99) < 3) a.sec_req_i = 0;
      a.zeroize_i = ($urandom_range(99) < (a.err_o ? 15 : 1));
      if ($urandom_range(199) == 0) a.eng_done_i = 1;
    end
    a.prim_req_i = 0; a.sec_req_i = 0; a.zeroize_i = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mldsa_seq_res_arb.md
# mldsa_seq_res_arb

Two-requester arbiter and launch controller for one shared MLDSA engine, such as the NTT or Keccak core. The primary sequencer and the secondary (signing) sequencer each request the engine with an opcode. The block picks one requester round-robin, launches the engine, and waits for completion. It then returns a done pulse to the owner, and a watchdog traps a hung engine. It sits between the two sequencer instruction decoders and the shared engine's start/done interface.

## Interface
- `OP_W`, 8: width of the engine opcode carried from requester to engine.
- `TIMEOUT`, 8191: maximum cycles in RUN before the watchdog fires; legal range 1..65535.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `zeroize_i` in 1: synchronous clear, highest priority after `rst`.
- `prim_req_i` in 1: primary requests the engine; held high until `prim_done_o`.
- `prim_op_i` in OP_W: primary opcode; stable while `prim_req_i` is high.
- `sec_req_i` in 1: secondary request; same rules as the primary.
- `sec_op_i` in OP_W: secondary opcode.
- `prim_gnt_o` out 1: primary owns the engine (START through DONE).
- `sec_gnt_o` out 1: secondary owns the engine.
- `prim_done_o` out 1: one-cycle pulse when the primary's operation completes.
- `sec_done_o` out 1: one-cycle pulse when the secondary's operation completes.
- `eng_start_o` out 1: one-cycle engine launch pulse.
- `eng_op_o` out OP_W: opcode latched at grant; held until the next grant.
- `eng_abort_o` out 1: one-cycle pulse when zeroize hits during START or RUN.
- `eng_done_i` in 1: engine completion pulse.
- `busy_o` out 1: state is not IDLE.
- `err_o` out 1: sticky watchdog or protocol error.

## Operation
- States: IDLE, START, RUN, DONE, ERR.
- `last_owner` is a 1-bit register; reset value SEC, so the primary wins the first tie.
- **IDLE:**
  - One request high: grant that requester.
  - Both high: grant the requester that is not `last_owner`.
  - On grant: latch the owner's opcode into `eng_op_o`, set the grant bit, and go to START.
- **START:** `eng_start_o`=1 for exactly this cycle; clear the watchdog counter; go to RUN.
- **RUN:**
  - Increment the watchdog counter each cycle.
  - `eng_done_i`: go to DONE.
  - Counter reaches TIMEOUT with no done: go to ERR.
- **DONE:**
  - The owner's done output is 1 for this cycle only; the grant is still high.
  - Update `last_owner` to the owner; both requests are ignored this cycle.
  - Next state is IDLE with the grant cleared.
  - A requester that keeps `req` high after its done is treated as a new request in IDLE.
- **ERR:**
  - `err_o`=1; grants, done outputs and start are all 0.
  - Requests are ignored; the block stays in ERR until `zeroize_i` or `rst`.
- **Protocol error:** `eng_done_i` seen in IDLE, START or DONE sets `err_o` and the next state is ERR.
- **Requester rules:** a requester that drops `req` while granted has no effect; the operation completes and the done pulse is still issued.
- **Zeroize:**
  - Next state IDLE; counter, grants, `eng_op_o` and `err_o` clear; `last_owner` returns to SEC.
  - `eng_abort_o` pulses the following cycle if the state was START or RUN.
  - Zeroize and `eng_done_i` in the same cycle: zeroize wins and no done pulse is issued.
- **Watchdog counter:** width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_owner`=SEC.
- **Registers:** every output is registered; there are no combinational paths from input to output.
- **Request to start:** a request sampled in IDLE at edge k gives grant high and state START after edge k; `eng_start_o` is high in the cycle between edges k and k+1.
- **Done to done-pulse:** `eng_done_i` sampled at edge m gives the done pulse in the cycle between m and m+1; `busy_o` falls after edge m+1.
- **Minimum back-to-back spacing:** 4 cycles per operation (START, RUN, DONE, IDLE) when the engine completes in one RUN cycle.
- **Watchdog boundary:** ERR is entered on the edge where the counter equals TIMEOUT. An `eng_done_i` arriving on that same edge wins: the next state is DONE, not ERR.

## Structure
- `mldsa_ctrl_pkg` gains:
  - `mldsa_arb_state_e` (5 states, 3-bit encoding).
  - `mldsa_arb_owner_e` (PRIM=0, SEC=1).
  - Localparam `MLDSA_ARB_TIMEOUT_DEFAULT` = 8191.
- One sub-module, `mldsa_arb_wdog`:
  - Contains the saturating counter plus compare.
  - Inputs: clear, enable. Output: expired.
  - Parameterised by TIMEOUT.
- Everything else is a single FSM plus the grant/opcode registers; estimated at about 200 RTL lines.

## Test plan
- **Single primary request:** `prim_req_i`=1, `prim_op_i`=0x21, engine done 10 cycles after start.
  - Expect `eng_op_o`=0x21.
  - Expect exactly one `eng_start_o` and one `prim_done_o` pulse.
  - Expect `sec_gnt_o` never set.
- **Contention:** both requests held high through 4 operations. Expect grant order P, S, P, S, with each done pulse matching its grant.
- **Watchdog:** TIMEOUT=16 and no engine done.
  - Expect `err_o`=1 exactly 16 cycles after RUN entry, with grants at 0.
  - Requests stay ignored until `zeroize_i`; afterwards `err_o`=0 and the next request is granted to the primary.
- **Zeroize during RUN:**
  - Expect `eng_abort_o` to pulse once and no done pulse; state returns to IDLE.
  - A simultaneous `eng_done_i` must not produce a done pulse.
- **Spurious done:** `eng_done_i` in IDLE. Expect `err_o`=1 and the block stuck in ERR.
- **Watchdog boundary:** `eng_done_i` on the TIMEOUT edge. Expect DONE reached and `err_o`=0.
- **Async reset in RUN:** assert `rst` mid-cycle. All outputs go to 0 immediately, without waiting for a clock edge.
